vga_grid_renderer: RTL and testbench

- Parametrised next-generation VGA raster engine for the snake game.
- Generates sync and pixel colour for a block grid drawn from packed snake/food coordinates.
- Adds generic timing, runtime snake length, distinct head colour, tear-free frame snapshots and a frame-start pulse for game logic.
- Replaces the per-pixel combinational compare against every snake piece with a per-scanline row-occupancy scan during horizontal blanking.

---
 rtl/vga_grid_renderer_pkg.sv | 23 ++
 rtl/vga_grid_renderer_if.sv | 21 ++
 rtl/vga_grid_renderer_timing.sv | 51 +++++
 rtl/vga_grid_renderer.sv | 174 +++++++++++++++++
 tb/tb_vga_grid_renderer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/vga_grid_renderer_pkg.sv
// vga_grid_renderer_pkg: colours, grid defaults, 640x480 timing and scan FSM states
package vga_grid_renderer_pkg;
  localparam logic [7:0] COLOR_WALL  = 8'h92;
  localparam logic [7:0] COLOR_FOOD  = 8'hE0;
  localparam logic [7:0] COLOR_HEAD  = 8'hFC;
  localparam logic [7:0] COLOR_SNAKE = 8'h1C;
  localparam logic [7:0] COLOR_EMPTY = 8'h25;
  localparam int DEF_GRID_WIDTH   = 16;
  localparam int DEF_GRID_HEIGHT  = 12;
  localparam int DEF_BLOCK_WIDTH  = 40;
  localparam int DEF_BLOCK_HEIGHT = 40;
  localparam int DEF_NUM_PIECES   = 32;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_V_BP     = 29;
  localparam int RST_SYNC_STAGES = 2;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} scan_state_e;
endpackage

// File: rtl/vga_grid_renderer_if.sv
// vga_grid_renderer_if: snake/food coordinates in, VGA pixel stream out
interface vga_grid_renderer_if #(
  parameter int XB = 4,
  parameter int YB = 4,
  parameter int NUM_PIECES = 32
);
  localparam int LW = $clog2(NUM_PIECES) + 1;
  logic [XB*NUM_PIECES-1:0] packSnakeX;
  logic [YB*NUM_PIECES-1:0] packSnakeY;
  logic [LW-1:0]            snakeLength;
  logic [XB-1:0]            foodX;
  logic [YB-1:0]            foodY;
  logic [7:0]               RGB;
  logic                     HSync;
  logic                     VSync;
  logic                     frameStart;
  modport master (output packSnakeX, packSnakeY, snakeLength, foodX, foodY,
                  input RGB, HSync, VSync, frameStart);
  modport slave  (input packSnakeX, packSnakeY, snakeLength, foodX, foodY,
                  output RGB, HSync, VSync, frameStart);
endinterface

// File: rtl/vga_grid_renderer_timing.sv
// vga_timing_gen: raster counters, active flags, raw syncs and frame-start strobe
module vga_timing_gen import vga_grid_renderer_pkg::*; #(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_PULSE  = DEF_H_PULSE,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_PULSE  = DEF_V_PULSE,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_PULSE + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_PULSE + V_BP,
  localparam int  HW       = $clog2(H_TOTAL),
  localparam int  VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          h_active,
  output logic          v_active,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          frame_start
);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last;
  always_comb begin
    h_last = h_q == HW'(H_TOTAL - 1);
    h_d    = h_last ? '0 : h_q + HW'(1);
    v_d    = !h_last ? v_q : (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign h_active    = h_q < HW'(H_ACTIVE);
  assign v_active    = v_q < VW'(V_ACTIVE);
  assign hsync_raw   = (h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_PULSE)) ? H_POL : ~H_POL;
  assign vsync_raw   = (v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_PULSE)) ? V_POL : ~V_POL;
  assign frame_start = h_q == '0 && v_q == VW'(V_ACTIVE);
endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: frame-snapshotted snake grid drawn via per-line row-occupancy scan
module vga_grid_renderer import vga_grid_renderer_pkg::*; #(
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_FP         = DEF_H_FP,
  parameter int   H_PULSE      = DEF_H_PULSE,
  parameter int   H_BP         = DEF_H_BP,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FP         = DEF_V_FP,
  parameter int   V_PULSE      = DEF_V_PULSE,
  parameter int   V_BP         = DEF_V_BP,
  parameter logic H_POL        = 1'b0,
  parameter logic V_POL        = 1'b0,
  parameter int   GRID_WIDTH   = DEF_GRID_WIDTH,
  parameter int   GRID_HEIGHT  = DEF_GRID_HEIGHT,
  parameter int   BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int   BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int   NUM_PIECES   = DEF_NUM_PIECES,
  parameter int   XB           = $clog2(GRID_WIDTH),
  parameter int   YB           = $clog2(GRID_HEIGHT)
) (
  input logic Clock,
  input logic Reset_n,
  vga_grid_renderer_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int LW  = $clog2(NUM_PIECES) + 1;
  localparam int IW  = $clog2(NUM_PIECES);
  localparam int XW  = XB + 1;
  localparam int YW  = YB + 1;
  localparam int XSW = $clog2(BLOCK_WIDTH + 1);
  localparam int YSW = $clog2(BLOCK_HEIGHT + 1);
  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic                       rst_n_i;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic h_active, v_active, hsync_raw, vsync_raw, frame_start, h_last;
  logic [XSW-1:0] x_sub_q, x_sub_d;
  logic [XW-1:0]  x_blk_q, x_blk_d;
  logic [YSW-1:0] y_sub_q, y_sub_d, y_sub_n;
  logic [YW-1:0]  y_blk_q, y_blk_d, y_blk_n;
  logic y_wrap, y_step;
  logic [NUM_PIECES-1:0][XB-1:0] snap_x_q, snap_x_d;
  logic [NUM_PIECES-1:0][YB-1:0] snap_y_q, snap_y_d;
  logic [LW-1:0] snap_len_q, snap_len_d;
  logic [XB-1:0] food_x_q, food_x_d, px;
  logic [YB-1:0] food_y_q, food_y_d, py;
  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [YW-1:0] target_q, target_d;
  logic [GRID_WIDTH-1:0] build_q, build_d, row_q, row_d;
  logic in_grid, wall, food, head, body;
  logic [7:0] rgb_q, rgb_d;
  logic hs_q, hs_d, vs_q, vs_d;
  // Asynchronous assertion, deassertion retimed to Clock
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
  assign rst_n_i = rst_sync_q[RST_SYNC_STAGES-1];
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL)
  ) u_timing (
    .clk(Clock), .rst_n(rst_n_i), .h_count(h_count), .v_count(v_count),
    .h_active(h_active), .v_active(v_active), .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw), .frame_start(frame_start)
  );
  // Block counters saturate one past the grid so out-of-grid pixels are detectable
  always_comb begin
    h_last  = h_count == HW'(H_TOTAL - 1);
    y_wrap  = v_count == VW'(V_TOTAL - 1);
    y_step  = y_sub_q == YSW'(BLOCK_HEIGHT - 1);
    y_sub_n = y_wrap ? '0 : !v_active ? y_sub_q : y_step ? '0 : y_sub_q + YSW'(1);
    y_blk_n = y_wrap ? '0 : (v_active && y_step && y_blk_q != YW'(GRID_HEIGHT)) ? y_blk_q + YW'(1) : y_blk_q;
    x_sub_d = h_last ? '0 : !h_active ? x_sub_q : (x_sub_q == XSW'(BLOCK_WIDTH - 1)) ? '0 : x_sub_q + XSW'(1);
    x_blk_d = h_last ? '0 : (h_active && x_sub_q == XSW'(BLOCK_WIDTH - 1) && x_blk_q != XW'(GRID_WIDTH)) ? x_blk_q + XW'(1) : x_blk_q;
    y_sub_d = h_last ? y_sub_n : y_sub_q;
    y_blk_d = h_last ? y_blk_n : y_blk_q;
  end
  always_comb begin
    snap_x_d   = frame_start ? bus.packSnakeX : snap_x_q;
    snap_y_d   = frame_start ? bus.packSnakeY : snap_y_q;
    food_x_d   = frame_start ? bus.foodX : food_x_q;
    food_y_d   = frame_start ? bus.foodY : food_y_q;
    snap_len_d = !frame_start ? snap_len_q :
                 (bus.snakeLength > LW'(NUM_PIECES)) ? LW'(NUM_PIECES) : bus.snakeLength;
  end
  // Body pieces of the next line are gathered during horizontal blanking
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    build_d  = build_q;
    row_d    = row_q;
    px       = snap_x_q[idx_q];
    py       = snap_y_q[idx_q];
    case (state_q)
      IDLE: if (h_count == HW'(H_ACTIVE)) begin
        state_d  = SCAN;
        idx_d    = IW'(1);
        target_d = y_blk_n;
      end
      SCAN: begin
        if ({1'b0, idx_q} < snap_len_q && {1'b0, py} == target_q &&
            {1'b0, px} < XW'(GRID_WIDTH) && {1'b0, py} < YW'(GRID_HEIGHT))
          build_d[px] = 1'b1;
        state_d = (idx_q == IW'(NUM_PIECES - 1)) ? COMMIT : SCAN;
        idx_d   = idx_q + IW'(1);
      end
      COMMIT: begin
        row_d   = build_q;
        build_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_grid = x_blk_q < XW'(GRID_WIDTH) && y_blk_q < YW'(GRID_HEIGHT);
    wall    = x_blk_q == '0 || x_blk_q == XW'(GRID_WIDTH - 1) || y_blk_q == '0 || y_blk_q == YW'(GRID_HEIGHT - 1);
    food    = x_blk_q == {1'b0, food_x_q} && y_blk_q == {1'b0, food_y_q};
    head    = snap_len_q != '0 && x_blk_q == {1'b0, snap_x_q[0]} && y_blk_q == {1'b0, snap_y_q[0]};
    body    = row_q[x_blk_q[XB-1:0]];
    rgb_d   = !(h_active && v_active) ? 8'h00 : !in_grid ? COLOR_EMPTY : wall ? COLOR_WALL :
              food ? COLOR_FOOD : head ? COLOR_HEAD : body ? COLOR_SNAKE : COLOR_EMPTY;
    hs_d    = hsync_raw;
    vs_d    = vsync_raw;
  end
  always_ff @(posedge Clock or negedge rst_n_i)
    if (!rst_n_i) begin
      x_sub_q    <= '0;
      x_blk_q    <= '0;
      y_sub_q    <= '0;
      y_blk_q    <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_len_q <= '0;
      food_x_q   <= '0;
      food_y_q   <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      target_q   <= '0;
      build_q    <= '0;
      row_q      <= '0;
      rgb_q      <= '0;
      hs_q       <= ~H_POL;
      vs_q       <= ~V_POL;
    end else begin
      x_sub_q    <= x_sub_d;
      x_blk_q    <= x_blk_d;
      y_sub_q    <= y_sub_d;
      y_blk_q    <= y_blk_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_len_q <= snap_len_d;
      food_x_q   <= food_x_d;
      food_y_q   <= food_y_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      build_q    <= build_d;
      row_q      <= row_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
    end
  assign bus.RGB        = rgb_q;
  assign bus.HSync      = hs_q;
  assign bus.VSync      = vs_q;
  assign bus.frameStart = frame_start;
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: scoreboard bench with a frame-level reference model on a reduced raster
module tb_vga_grid_renderer;
  import vga_grid_renderer_pkg::*;
  localparam int HA = 36, HF = 3, HP = 5, HB = 4;
  localparam int VA = 14, VF = 2, VP = 2, VB = 3;
  localparam logic HPOL = 1'b1, VPOL = 1'b0;
  localparam int GW = 6, GH = 6, BW = 5, BH = 2, NP = 8;
  localparam int XB = 3, YB = 3, LW = 4;
  localparam int HT = HA + HF + HP + HB, VT = VA + VF + VP + VB;
  typedef struct packed {logic [7:0] rgb; logic hs; logic vs; logic fs;} obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vga_grid_renderer_if #(.XB(XB), .YB(YB), .NUM_PIECES(NP)) bus();
  vga_grid_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL),
    .GRID_WIDTH(GW), .GRID_HEIGHT(GH), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH),
    .NUM_PIECES(NP), .XB(XB), .YB(YB)
  ) dut (.Clock(clk), .Reset_n(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  int mh = 0, mv = 0, hold = 0;
  int sx[NP], sy[NP];
  int slen = 0, sfx = 0, sfy = 0;
  obs_t exp_q[$];
  function automatic logic [7:0] ref_rgb(int h, int v);
    int xb, yb;
    if (h >= HA || v >= VA) return 8'h00;
    xb = h / BW;
    yb = v / BH;
    if (xb >= GW || yb >= GH) return COLOR_EMPTY;
    if (xb == 0 || xb == GW - 1 || yb == 0 || yb == GH - 1) return COLOR_WALL;
    if (xb == sfx && yb == sfy) return COLOR_FOOD;
    if (slen >= 1 && xb == sx[0] && yb == sy[0]) return COLOR_HEAD;
    for (int i = 1; i < slen; i++)
      if (sx[i] == xb && sy[i] == yb) return COLOR_SNAKE;
    return COLOR_EMPTY;
  endfunction
  // Reference raster: one expected output word per clock edge
  always @(posedge clk) begin
    obs_t e;
    if (!rst_n || hold > 0) begin
      if (!rst_n) begin
        hold = RST_SYNC_STAGES;
        mh = 0; mv = 0; slen = 0; sfx = 0; sfy = 0;
        foreach (sx[i]) begin sx[i] = 0; sy[i] = 0; end
      end else hold--;
      e = '{8'h00, ~HPOL, ~VPOL, 1'b0};
    end else begin
      if (mh == 0 && mv == VA) begin
        for (int i = 0; i < NP; i++) begin
          sx[i] = int'(bus.packSnakeX[i*XB +: XB]);
          sy[i] = int'(bus.packSnakeY[i*YB +: YB]);
        end
        slen = int'(bus.snakeLength) > NP ? NP : int'(bus.snakeLength);
        sfx = int'(bus.foodX);
        sfy = int'(bus.foodY);
      end
      e.rgb = ref_rgb(mh, mv);
      e.hs = (mh >= HA + HF && mh < HA + HF + HP) ? HPOL : ~HPOL;
      e.vs = (mv >= VA + VF && mv < VA + VF + VP) ? VPOL : ~VPOL;
      if (mh == HT - 1) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
      else mh++;
      e.fs = (mh == 0 && mv == VA);
    end
    exp_q.push_back(e);
  end
  always @(posedge clk) begin
    obs_t e, a;
    #2;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry at check %0d", checks);
    end else begin
      e = exp_q.pop_front();
      a = {bus.RGB, bus.HSync, bus.VSync, bus.frameStart};
      if (a !== e) begin
        errors++;
        $display("FAIL pixel check %0d (model h=%0d v=%0d): got rgb=%h hs=%b vs=%b fs=%b, expected rgb=%h hs=%b vs=%b fs=%b",
                 checks, mh, mv, a.rgb, a.hs, a.vs, a.fs, e.rgb, e.hs, e.vs, e.fs);
      end
    end
  end
  task automatic wait_pos(int h, int v);
    int n = 0;
    while (!(mh == h && mv == v && hold == 0 && rst_n)) begin
      @(negedge clk);
      n++;
      if (n > 2 * HT * VT) begin
        errors++; checks++;
        $display("FAIL wait_pos timeout: position h=%0d v=%0d never reached", h, v);
        return;
      end
    end
  endtask
  task automatic clear_snake();
    for (int i = 0; i < NP; i++) begin
      bus.packSnakeX[i*XB +: XB] = XB'(7);
      bus.packSnakeY[i*YB +: YB] = YB'(7);
    end
  endtask
  task automatic set_piece(int i, int x, int y);
    bus.packSnakeX[i*XB +: XB] = XB'(x);
    bus.packSnakeY[i*YB +: YB] = YB'(y);
  endtask
  task automatic set_misc(int len, int fx, int fy);
    bus.snakeLength = LW'(len);
    bus.foodX = XB'(fx);
    bus.foodY = YB'(fy);
  endtask
  task automatic rand_inputs();
    for (int i = 0; i < NP; i++) set_piece(i, $urandom_range(0, 7), $urandom_range(0, 7));
    set_misc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) set_misc(int'(bus.snakeLength), int'(bus.packSnakeX[XB-1:0]), int'(bus.packSnakeY[YB-1:0]));
  endtask
  task automatic two_frames();
    wait_pos(0, VA + 1);
    wait_pos(0, VA - 1);
    wait_pos(0, VA + 1);
    wait_pos(0, VA - 1);
  endtask
  initial begin
    clear_snake();
    set_misc(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // head at (2,2), body (3,2),(4,2), food (1,1)
    set_piece(0, 2, 2); set_piece(1, 3, 2); set_piece(2, 4, 2);
    set_misc(3, 1, 1);
    two_frames();
    set_misc(2, 1, 1);
    two_frames();
    set_misc(3, 0, 3);
    two_frames();
    set_piece(0, 3, 3);
    set_misc(3, 3, 3);
    two_frames();
    clear_snake();
    for (int i = 0; i < NP; i++) set_piece(i, 1 + i % 4, 1 + i / 4);
    set_misc(15, 7, 7);
    two_frames();
    set_misc(8, 1, 4);
    wait_pos(0, VA + 1);
    wait_pos(0, 5);
    bus.foodX = XB'(4);
    two_frames();
    // reset while the row scan of line 7 is in progress
    wait_pos(HA + 2, 7);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.RGB !== 8'h00 || bus.HSync !== ~HPOL || bus.VSync !== ~VPOL || bus.frameStart !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: got rgb=%h hs=%b vs=%b fs=%b, expected rgb=00 hs=%b vs=%b fs=0",
               bus.RGB, bus.HSync, bus.VSync, bus.frameStart, ~HPOL, ~VPOL);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    two_frames();
    for (int f = 0; f < 25; f++) begin
      rand_inputs();
      repeat ($urandom_range(1, 2)) begin
        repeat ($urandom_range(100, 600)) @(negedge clk);
        rand_inputs();
      end
      wait_pos(0, VA + 1);
    end
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
